// File: rtl/pipe_stall_regs.sv
// PC, IF/ID and ID/EX registers driven by the load-use hazard unit and EX branch flush.
// Optional STALL_COUNTER_EN macro adds a saturating stall-cycle counter on stall_cnt.
module pipe_stall_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic              if_id_write,
  input  logic              id_ex_control,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       imem_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  output logic [31:0]       pc,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc4,
  output logic              if_id_valid,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic [4:0]        id_ex_rs,
  output logic [4:0]        id_ex_rt,
  output logic              id_ex_valid,
  output logic [1:0]        pipe_state,
  output logic              hazard_err,
  output logic [31:0]       stall_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic              valid;
  } id_ex_t;

  state_t      state_q, state_d;
  if_id_t      if_id_q;
  id_ex_t      id_ex_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        mismatch;
  logic        err_q;

  assign pc_plus4 = pc_q + 32'd4;
  assign stall    = !pc_write && !if_id_write && !id_ex_control;
  // The hazard unit should always move all three enables together.
  assign mismatch = (pc_write != if_id_write) || (if_id_write != id_ex_control);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      if_id_q <= '0;
      id_ex_q <= '0;
      state_q <= RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mismatch) err_q <= 1'b1;

      if (branch_taken)  pc_q <= branch_target;
      else if (pc_write) pc_q <= pc_plus4;

      if (branch_taken) begin
        if_id_q <= '0;
      end else if (if_id_write) begin
        if_id_q.instr <= imem_instr;
        if_id_q.pc4   <= pc_plus4;
        if_id_q.valid <= 1'b1;
      end

      // Control is captured even behind an empty IF/ID; valid qualifies it.
      if (branch_taken || !id_ex_control) begin
        id_ex_q <= '0;
      end else begin
        id_ex_q.ctrl  <= id_ctrl;
        id_ex_q.rs    <= id_rs;
        id_ex_q.rt    <= id_rt;
        id_ex_q.valid <= if_id_q.valid;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (branch_taken) state_d = FLUSH;
               else if (stall)   state_d = STALL;
      STALL:   if (branch_taken) state_d = FLUSH;
               else if (!stall)  state_d = RUN;
      FLUSH:   if (branch_taken) state_d = FLUSH;
               else if (stall)   state_d = STALL;
               else              state_d = RUN;
      default: state_d = RUN;
    endcase
  end

`ifdef STALL_COUNTER_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (state_d == STALL && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

  assign pc          = pc_q;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_valid = if_id_q.valid;
  assign id_ex_ctrl  = id_ex_q.ctrl;
  assign id_ex_rs    = id_ex_q.rs;
  assign id_ex_rt    = id_ex_q.rt;
  assign id_ex_valid = id_ex_q.valid;
  assign pipe_state  = state_q;
  assign hazard_err  = err_q;

endmodule
